// File: rtl/count_ones_arb_if.sv
// Request/response bundle between two requesters and the shared ones-counter.
// master drives requests and operands; slave (the counter) returns grants and results.
interface count_ones_arb_if #(
  parameter int unsigned DataWidth  = 4,
  parameter int unsigned CountWidth = 3
) ();

  logic                  req_a;
  logic [DataWidth-1:0]  data_a;
  logic                  req_b;
  logic [DataWidth-1:0]  data_b;
  logic                  gnt_a;
  logic                  gnt_b;
  logic                  busy;
  logic                  done;
  logic                  owner;
  logic [CountWidth-1:0] bit_count;

  modport master (
    output req_a, data_a, req_b, data_b,
    input  gnt_a, gnt_b, busy, done, owner, bit_count
  );

  modport slave (
    input  req_a, data_a, req_b, data_b,
    output gnt_a, gnt_b, busy, done, owner, bit_count
  );

endinterface

// File: rtl/count_ones_arb.sv
// Two-requester round-robin arbiter in front of a serial population counter.
// A captured word is shifted out LSB-first until only zeros remain; every output is registered.
module count_ones_arb #(
  parameter int unsigned DataWidth  = 4,
  parameter int unsigned CountWidth = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  count_ones_arb_if.slave        bus_io
);

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [DataWidth-1:0]  shift_q, shift_d;
  logic [CountWidth-1:0] acc_q, acc_d;
  logic [CountWidth-1:0] bit_count_q, bit_count_d;
  logic                  owner_q, owner_d;
  logic                  gnt_a_q, gnt_a_d;
  logic                  gnt_b_q, gnt_b_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  // High when B has priority on a tie, i.e. A was served last.
  logic                  prio_b_q, prio_b_d;

  logic                  any_req;
  logic                  win_b;
  logic [DataWidth-1:0]  shifted;
  logic [CountWidth-1:0] acc_sum;

  always_comb begin
    any_req = bus_io.req_a | bus_io.req_b;
    win_b   = bus_io.req_b & (~bus_io.req_a | prio_b_q);
    shifted = shift_q >> 1;
    acc_sum = acc_q + {{(CountWidth-1){1'b0}}, shift_q[0]};
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    acc_d       = acc_q;
    bit_count_d = bit_count_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    prio_b_d    = prio_b_q;
    gnt_a_d     = 1'b0;
    gnt_b_d     = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (any_req) begin
          shift_d  = win_b ? bus_io.data_b : bus_io.data_a;
          acc_d    = '0;
          owner_d  = win_b;
          gnt_a_d  = ~win_b;
          gnt_b_d  = win_b;
          busy_d   = 1'b1;
          prio_b_d = ~win_b;
          state_d  = StCount;
        end
      end

      StCount: begin
        acc_d   = acc_sum;
        shift_d = shifted;
        // Stop as soon as the remaining bits are all zero; this folds in the current LSB.
        if (shifted == '0) begin
          bit_count_d = acc_sum;
          done_d      = 1'b1;
          state_d     = StDone;
        end
      end

      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      acc_q       <= '0;
      bit_count_q <= '0;
      owner_q     <= 1'b0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      prio_b_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      bit_count_q <= bit_count_d;
      owner_q     <= owner_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      prio_b_q    <= prio_b_d;
    end
  end

  assign bus_io.gnt_a     = gnt_a_q;
  assign bus_io.gnt_b     = gnt_b_q;
  assign bus_io.done      = done_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.owner     = owner_q;
  assign bus_io.bit_count = bit_count_q;

endmodule

// File: tb/tb_count_ones_arb.sv
// Randomised bench for count_ones_arb against a population-count / round-robin model.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_count_ones_arb;

  localparam int unsigned DataWidth  = 4;
  localparam int unsigned CountWidth = 3;

  logic clk;
  logic rst_ni;

  int n_checks;
  int n_pass;
  bit prio_b;  // model: B wins the next tie

  count_ones_arb_if #(.DataWidth(DataWidth), .CountWidth(CountWidth)) bus ();

  count_ones_arb #(
    .DataWidth (DataWidth),
    .CountWidth(CountWidth)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_gnt_a"}, 32'(bus.gnt_a), 0);
    check_eq({tag, "_gnt_b"}, 32'(bus.gnt_b), 0);
    check_eq({tag, "_done"}, 32'(bus.done), 0);
    check_eq({tag, "_busy"}, 32'(bus.busy), 0);
    check_eq({tag, "_owner"}, 32'(bus.owner), 0);
    check_eq({tag, "_count"}, 32'(bus.bit_count), 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_ni     = 1'b0;
    bus.req_a  = 1'b0;
    bus.req_b  = 1'b0;
    prio_b     = 1'b0;
    #1;
    check_cleared("reset");
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // Starts and finishes one transaction; must be entered on a falling edge in IDLE.
  task automatic do_op(input logic ra, input logic [3:0] da, input logic rb,
                       input logic [3:0] db, input bit keep);
    bit             win;
    logic [3:0]     d;
    int             exp_cycles;
    int             n;
    bus.req_a  = ra;
    bus.data_a = da;
    bus.req_b  = rb;
    bus.data_b = db;
    win    = (ra && rb) ? prio_b : rb;
    prio_b = !win;
    d      = win ? db : da;
    exp_cycles = (d == 0) ? 1 : $clog2(int'(d) + 1);

    @(negedge clk);
    check_eq("gnt_a", 32'(bus.gnt_a), 32'(!win));
    check_eq("gnt_b", 32'(bus.gnt_b), 32'(win));
    check_eq("busy_count", 32'(bus.busy), 1);
    n = 0;
    while (!bus.done && n < 20) begin
      n++;
      // Operands and, unless held, requests wander while the count runs.
      bus.data_a = 4'($urandom);
      bus.data_b = 4'($urandom);
      if (!keep) begin
        bus.req_a = 1'($urandom);
        bus.req_b = 1'($urandom);
      end
      @(negedge clk);
      check_eq("gnt_low", 32'({bus.gnt_a, bus.gnt_b}), 0);
    end
    check_eq("done_seen", 32'(bus.done), 1);
    check_eq("count_cycles", n, exp_cycles);
    check_eq("bit_count", 32'(bus.bit_count), $countones(d));
    check_eq("owner", 32'(bus.owner), 32'(win));
    check_eq("busy_done", 32'(bus.busy), 1);
    if (!keep) begin
      bus.req_a = 1'b0;
      bus.req_b = 1'b0;
    end
    @(negedge clk);
    check_eq("done_pulse", 32'(bus.done), 0);
    check_eq("busy_idle", 32'(bus.busy), 0);
    check_eq("hold_count", 32'(bus.bit_count), $countones(d));
  endtask

  initial begin
    logic ra;
    logic rb;
    n_checks   = 0;
    n_pass     = 0;
    prio_b     = 1'b0;
    rst_ni     = 1'b0;
    bus.req_a  = 1'b0;
    bus.req_b  = 1'b0;
    bus.data_a = '0;
    bus.data_b = '0;

    apply_reset();
    @(negedge clk);

    do_op(1'b1, 4'hf, 1'b0, 4'h0, 1'b0);
    do_op(1'b1, 4'h0, 1'b0, 4'h0, 1'b0);
    do_op(1'b0, 4'h0, 1'b1, 4'h5, 1'b0);
    do_op(1'b0, 4'h0, 1'b1, 4'hb, 1'b0);

    // Both requests held from reset: service alternates A, B, A, B.
    apply_reset();
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    for (int i = 0; i < 4; i++) do_op(1'b1, 4'($urandom), 1'b1, 4'($urandom), 1'b1);
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    @(negedge clk);

    // Operand changes mid-count have no effect.
    do_op(1'b1, 4'ha, 1'b0, 4'h0, 1'b0);

    // Reset in the middle of a count aborts it without a done pulse.
    bus.req_a  = 1'b1;
    bus.data_a = 4'hf;
    @(negedge clk);
    check_eq("abort_busy", 32'(bus.busy), 1);
    bus.req_a = 1'b0;
    @(posedge clk);
    #2;
    rst_ni = 1'b0;
    prio_b = 1'b0;
    #1;
    check_cleared("abort");
    @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("abort_no_done", 32'(bus.done), 0);
    end
    do_op(1'b0, 4'h0, 1'b1, 4'h7, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = 1'($urandom);
      rb = 1'($urandom);
      if (!ra && !rb) ra = 1'b1;
      do_op(ra, 4'($urandom), rb, 4'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
